// File: rtl/l2_mem_burst_adaptor_if.sv
// ---------------------------------------------------------------------------
// l2_mem_burst_adaptor_if
// Purpose : bundles the L2 cacheline request/response signals and the
//           64-bit memory burst bus that l2_mem_burst_adaptor bridges.
// Signals : line_addr_i/line_i/line_read_i/line_write_i  L2 -> adaptor
//           line_o/line_resp_o                            adaptor -> L2
//           mem_addr_o/mem_read_o/mem_write_o/mem_wdata_o adaptor -> memory
//           mem_rdata_i/mem_resp_i                        memory -> adaptor
// Modports: slave  - the adaptor side (consumes L2 requests, drives memory)
//           master - the environment side (L2 plus memory model)
// ---------------------------------------------------------------------------
interface l2_mem_burst_adaptor_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
);
  logic [31:0]       line_addr_i;
  logic [s_line-1:0] line_i;
  logic              line_read_i;
  logic              line_write_i;
  logic [s_line-1:0] line_o;
  logic              line_resp_o;
  logic [31:0]       mem_addr_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [s_beat-1:0] mem_wdata_o;
  logic [s_beat-1:0] mem_rdata_i;
  logic              mem_resp_i;

  modport slave (
    input  line_addr_i, line_i, line_read_i, line_write_i,
    input  mem_rdata_i, mem_resp_i,
    output line_o, line_resp_o,
    output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
  );

  modport master (
    output line_addr_i, line_i, line_read_i, line_write_i,
    output mem_rdata_i, mem_resp_i,
    input  line_o, line_resp_o,
    input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o
  );
endinterface

// File: rtl/l2_mem_burst_adaptor.sv
// ---------------------------------------------------------------------------
// l2_mem_burst_adaptor
// Purpose : memory-side end of the L2 line interface. A 256-bit fill or
//           writeback request is turned into a 4-beat 64-bit burst; a
//           single-cycle line_resp_o pulse signals completion.
// Ports   : clk  - clock
//           rst  - synchronous, active-high reset
//           bus  - l2_mem_burst_adaptor_if.slave (L2 line side + memory bus)
// All outputs are registered; the output process computes the value each
// output takes after the next edge, based on the next state.
// ---------------------------------------------------------------------------
module l2_mem_burst_adaptor #(
  parameter int s_line    = 256,
  parameter int s_beat    = 64,
  parameter int num_beats = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  l2_mem_burst_adaptor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] last_beat = 2'(num_beats - 1);

  state_t            state_r;
  state_t            state_n;
  logic [1:0]        count_r;
  logic [1:0]        count_d;
  logic [s_line-1:0] wline_r;
  logic [s_line-1:0] wline_d;
  logic [s_line-1:0] line_d;
  logic [31:0]       addr_d;
  logic [s_beat-1:0] wdata_d;
  logic              read_d;
  logic              write_d;
  logic              resp_d;
  logic              last_ack_s;

  // A beat acknowledge that completes the final beat of the burst.
  assign last_ack_s = bus.mem_resp_i && (count_r == last_beat);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; a writeback takes priority over a simultaneous fill.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.line_write_i) begin
          state_n = WRITE;
        end else if (bus.line_read_i) begin
          state_n = READ;
        end else begin
          state_n = IDLE;
        end
      end
      READ: begin
        if (last_ack_s) begin
          state_n = DONE;
        end else begin
          state_n = READ;
        end
      end
      WRITE: begin
        if (last_ack_s) begin
          state_n = DONE;
        end else begin
          state_n = WRITE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output/datapath next values, registered below.
  always_comb begin
    count_d = count_r;
    addr_d  = bus.mem_addr_o;
    wline_d = wline_r;
    line_d  = bus.line_o;
    read_d  = (state_n == READ);
    write_d = (state_n == WRITE);
    resp_d  = (state_n == DONE);
    case (state_r)
      IDLE: begin
        if (state_n != IDLE) begin
          count_d = 2'd0;
          // Offset bits are masked to zero so the burst is line aligned.
          addr_d  = {bus.line_addr_i[31:5], bus.line_addr_i[4:0] & 5'b00000};
          if (state_n == WRITE) begin
            wline_d = bus.line_i;
          end else begin
            wline_d = wline_r;
          end
        end else begin
          count_d = count_r;
        end
      end
      READ: begin
        if (bus.mem_resp_i) begin
          // Beats overwrite the previous fill in place.
          line_d[s_beat*count_r +: s_beat] = bus.mem_rdata_i;
          count_d = count_r + 2'd1;
        end else begin
          count_d = count_r;
        end
      end
      WRITE: begin
        if (bus.mem_resp_i) begin
          count_d = count_r + 2'd1;
        end else begin
          count_d = count_r;
        end
      end
      DONE:    count_d = count_r;
      default: count_d = 2'd0;
    endcase
    // The write beat on the bus always tracks the count it will hold next.
    if (state_n == WRITE) begin
      wdata_d = wline_d[s_beat*count_d +: s_beat];
    end else begin
      wdata_d = {s_beat{1'b0}};
    end
  end

  // Registered outputs and latched request data.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r         <= 2'd0;
      wline_r         <= {s_line{1'b0}};
      bus.line_o      <= {s_line{1'b0}};
      bus.line_resp_o <= 1'b0;
      bus.mem_addr_o  <= 32'd0;
      bus.mem_read_o  <= 1'b0;
      bus.mem_write_o <= 1'b0;
      bus.mem_wdata_o <= {s_beat{1'b0}};
    end else begin
      count_r         <= count_d;
      wline_r         <= wline_d;
      bus.line_o      <= line_d;
      bus.line_resp_o <= resp_d;
      bus.mem_addr_o  <= addr_d;
      bus.mem_read_o  <= read_d;
      bus.mem_write_o <= write_d;
      bus.mem_wdata_o <= wdata_d;
    end
  end

endmodule

// File: tb/tb_l2_mem_burst_adaptor.sv
// ---------------------------------------------------------------------------
// tb_l2_mem_burst_adaptor
// Directed bench for l2_mem_burst_adaptor: fills, writebacks, wait states,
// simultaneous requests, reset mid-burst and input changes mid-burst.
// Inputs are driven 1 time unit after the rising edge, outputs are checked
// at the same point; cycle numbers follow the request-in-IDLE = cycle 0 rule.
// ---------------------------------------------------------------------------
module tb_l2_mem_burst_adaptor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   pulses;
  int   both_cnt;

  l2_mem_burst_adaptor_if bus ();

  l2_mem_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mid-cycle monitor: counts response pulses and illegal read+write overlap.
  always @(negedge clk) begin
    if (bus.line_resp_o === 1'b1) pulses++;
    if (bus.mem_read_o === 1'b1 && bus.mem_write_o === 1'b1) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill with 'waits' idle cycles before every beat; checks address, the
  // response at cycle 1+4*(waits+1), the assembled line and a single pulse.
  task automatic run_fill(input string tag, input logic [31:0] addr,
                          input logic [255:0] data, input int waits);
    int drops;
    int p0;
    logic [31:0] exp_addr;
    drops    = 0;
    p0       = pulses;
    exp_addr = {addr[31:5], 5'b00000};
    bus.line_addr_i = addr;
    bus.line_read_i = 1'b1;
    step();
    check_val({tag, " addr"}, 256'(bus.mem_addr_o), 256'(exp_addr));
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < waits; w++) begin
        bus.mem_resp_i = 1'b0;
        if (bus.mem_read_o !== 1'b1 || bus.line_resp_o !== 1'b0) drops++;
        step();
      end
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = data[64*k +: 64];
      if (bus.mem_read_o !== 1'b1 || bus.line_resp_o !== 1'b0) drops++;
      step();
    end
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = 64'd0;
    check_val({tag, " resp"}, 256'(bus.line_resp_o), 256'(1'b1));
    check_val({tag, " rd_drop"}, 256'(bus.mem_read_o), 256'(1'b0));
    check_val({tag, " line"}, bus.line_o, data);
    bus.line_read_i = 1'b0;
    step();
    check_val({tag, " resp_end"}, 256'(bus.line_resp_o), 256'(1'b0));
    check_val({tag, " pulses"}, 256'(pulses - p0), 256'(1));
    check_val({tag, " steady"}, 256'(drops), 256'(0));
  endtask

  logic [255:0] fill_a;
  logic [255:0] fill_b;
  logic [255:0] fill_c;
  logic [255:0] wb_line;
  int           p_start;

  initial begin
    n_cmp = 0; n_err = 0; pulses = 0; both_cnt = 0;
    rst = 1'b1;
    bus.line_addr_i  = 32'd0;
    bus.line_i       = 256'd0;
    bus.line_read_i  = 1'b0;
    bus.line_write_i = 1'b0;
    bus.mem_rdata_i  = 64'd0;
    bus.mem_resp_i   = 1'b0;
    fill_a  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    fill_b  = {64'h0F0E_0D0C_0B0A_0908, 64'h8899_AABB_CCDD_EEFF,
               64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D};
    fill_c  = {64'hA5A5_A5A5_0000_0001, 64'h5A5A_5A5A_0000_0002,
               64'hFFFF_0000_FFFF_0003, 64'h0000_FFFF_0000_0004};
    wb_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    step();
    step();

    // Reset state
    check_val("rst line_o", bus.line_o, 256'd0);
    check_val("rst resp", 256'(bus.line_resp_o), 256'd0);
    check_val("rst rd", 256'(bus.mem_read_o), 256'd0);
    check_val("rst wr", 256'(bus.mem_write_o), 256'd0);
    check_val("rst addr", 256'(bus.mem_addr_o), 256'd0);
    check_val("rst wdata", 256'(bus.mem_wdata_o), 256'd0);
    rst = 1'b0;
    step();

    // Zero-wait fill
    run_fill("fill0", 32'h0000_1234, fill_a, 0);

    // mem_resp_i in IDLE is ignored; line_o holds the last fill
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    step();
    check_val("idle rd", 256'(bus.mem_read_o), 256'd0);
    check_val("idle resp", 256'(bus.line_resp_o), 256'd0);
    check_val("idle hold", bus.line_o, fill_a);
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = 64'd0;
    step();

    // Writeback, with line_i/line_addr_i altered during beat 1
    p_start = pulses;
    bus.line_addr_i  = 32'hFFFF_FFE0;
    bus.line_i       = wb_line;
    bus.line_write_i = 1'b1;
    step();
    check_val("wb wr", 256'(bus.mem_write_o), 256'd1);
    check_val("wb addr", 256'(bus.mem_addr_o), 256'(32'hFFFF_FFE0));
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("wb beat%0d", k), 256'(bus.mem_wdata_o), 256'(wb_line[64*k +: 64]));
      bus.mem_resp_i = 1'b1;
      if (k == 1) begin
        bus.line_i      = ~wb_line;
        bus.line_addr_i = 32'h0000_0040;
      end
      if (k == 2) check_val("wb addr held", 256'(bus.mem_addr_o), 256'(32'hFFFF_FFE0));
      step();
    end
    bus.mem_resp_i = 1'b0;
    check_val("wb resp", 256'(bus.line_resp_o), 256'd1);
    check_val("wb wr_drop", 256'(bus.mem_write_o), 256'd0);
    bus.line_write_i = 1'b0;
    step();
    check_val("wb pulses", 256'(pulses - p_start), 256'd1);

    // Fill with 3 wait cycles per beat: response at cycle 17
    run_fill("fillws", 32'h8000_003F, fill_b, 3);

    // Simultaneous request: writeback first, then the held fill
    p_start = pulses;
    bus.line_addr_i  = 32'h0000_0100;
    bus.line_i       = wb_line;
    bus.line_read_i  = 1'b1;
    bus.line_write_i = 1'b1;
    step();
    check_val("both wr", 256'(bus.mem_write_o), 256'd1);
    check_val("both rd", 256'(bus.mem_read_o), 256'd0);
    bus.mem_resp_i = 1'b1;
    repeat (4) step();
    bus.mem_resp_i = 1'b0;
    check_val("both resp1", 256'(bus.line_resp_o), 256'd1);
    bus.line_write_i = 1'b0;
    step();
    check_val("both idle rd", 256'(bus.mem_read_o), 256'd0);
    step();
    check_val("both rd start", 256'(bus.mem_read_o), 256'd1);
    for (int k = 0; k < 4; k++) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = fill_c[64*k +: 64];
      step();
    end
    bus.mem_resp_i = 1'b0;
    check_val("both resp2", 256'(bus.line_resp_o), 256'd1);
    check_val("both line", bus.line_o, fill_c);
    bus.line_read_i = 1'b0;
    step();
    check_val("both pulses", 256'(pulses - p_start), 256'd2);

    // Reset after three beats of a fill
    p_start = pulses;
    bus.line_addr_i = 32'h0000_2000;
    bus.line_read_i = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      bus.mem_resp_i  = 1'b1;
      bus.mem_rdata_i = fill_a[64*k +: 64];
      step();
    end
    bus.mem_resp_i = 1'b0;
    rst = 1'b1;
    step();
    check_val("mrst rd", 256'(bus.mem_read_o), 256'd0);
    check_val("mrst line", bus.line_o, 256'd0);
    check_val("mrst resp", 256'(bus.line_resp_o), 256'd0);
    check_val("mrst addr", 256'(bus.mem_addr_o), 256'd0);
    rst = 1'b0;
    bus.line_read_i = 1'b0;
    step();
    check_val("mrst pulses", 256'(pulses - p_start), 256'd0);
    run_fill("fillpost", 32'h0000_3008, fill_b, 0);

    check_val("rd_wr overlap", 256'(both_cnt), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
